br_resolve_unit: RTL

//  Pipelined, parametrised branch resolution unit for the OOO core. Takes issued branches from the

---
 rtl/br_resolve_unit_pkg.sv | 60 ++++++
 rtl/br_resolve_unit_fifo.sv | 53 +++++
 rtl/br_resolve_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/br_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: funct3 encodings, result record, illegal-funct3 list.
// BRU_JUMP_EN adds the 4-bit bru_op_t with JAL/JALR and a queued link value.
package br_resolve_unit_pkg;

  localparam int BRU_XLEN  = 32;
  localparam int BRU_TAG_W = 5;

`ifdef BRU_JUMP_EN
  localparam int BRU_OP_W = 4;
`else
  localparam int BRU_OP_W = 3;
`endif

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

`ifdef BRU_JUMP_EN
  // MSB clear: conditional branch carried in the low three bits.
  typedef enum logic [3:0] {
    OP_BEQ  = 4'b0000,
    OP_BNE  = 4'b0001,
    OP_BLT  = 4'b0100,
    OP_BGE  = 4'b0101,
    OP_BLTU = 4'b0110,
    OP_BGEU = 4'b0111,
    OP_JAL  = 4'b1000,
    OP_JALR = 4'b1001
  } bru_op_t;
`endif

  localparam logic [2:0] BRU_ILLEGAL_F3 [2] = '{3'b010, 3'b011};

  // Default-width view of a result for consumers outside the unit.
  typedef struct packed {
    logic [BRU_TAG_W-1:0] tag;
    logic                 taken;
    logic [BRU_XLEN-1:0]  next_pc;
    logic                 mispredict;
    logic                 illegal;
`ifdef BRU_JUMP_EN
    logic [BRU_XLEN-1:0]  link;
`endif
  } bru_result_t;

  function automatic logic f3_is_illegal(input logic [2:0] f3);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < $size(BRU_ILLEGAL_F3); i++) begin
      if (f3 == BRU_ILLEGAL_F3[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/br_resolve_unit_fifo.sv
// br_result_fifo: generic result queue, entry type and depth parametrised, extra-MSB pointers.
// Push while full is taken only together with a pop of the head.
module br_result_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T            r_mem [DEPTH];
  logic        w_push_ok;
  logic        w_pop_ok;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing is visible while empty.
  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolve unit: S1 resolve register feeding a result FIFO; two-cycle issue-to-result latency.
// Optional JAL/JALR support and out_link port under BRU_JUMP_EN.
module br_resolve_unit
  import br_resolve_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5,
  parameter int QDEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BRU_OP_W-1:0] in_funct3,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [XLEN-1:0]     in_a,
  input  logic [XLEN-1:0]     in_b,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_imm,
  input  logic                in_pred_taken,
  input  logic [XLEN-1:0]     in_pred_tgt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_taken,
  output logic [XLEN-1:0]     out_next_pc,
  output logic                out_mispredict,
`ifdef BRU_JUMP_EN
  output logic [XLEN-1:0]     out_link,
`endif
  output logic                out_illegal
);

  localparam int CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic [XLEN-1:0]  next_pc;
    logic             mispredict;
    logic             illegal;
`ifdef BRU_JUMP_EN
    logic [XLEN-1:0]  link;
`endif
  } res_t;

  logic [2:0]      w_f3;
  logic            w_br_taken;
  logic            w_br_illegal;
  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_dest;
  logic            w_taken;
  logic            w_illegal;
  logic            w_tgt_only;
  logic            w_mispredict;
  res_t            w_res;
  res_t            r_s1;
  logic            r_s1_valid;
  res_t            w_head;
  res_t            w_out;
  logic            w_accept;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_occ;

`ifdef BRU_JUMP_EN
  assign w_f3 = in_funct3[2:0];
`else
  assign w_f3 = in_funct3;
`endif

  assign w_seq = in_pc + XLEN'(4);

  always_comb begin
    w_br_taken   = 1'b0;
    w_br_illegal = f3_is_illegal(w_f3);
    case (branch_funct3_t'(w_f3))
      F3_BEQ:  w_br_taken = (in_a == in_b);
      F3_BNE:  w_br_taken = (in_a != in_b);
      F3_BLT:  w_br_taken = ($signed(in_a) <  $signed(in_b));
      F3_BGE:  w_br_taken = ($signed(in_a) >= $signed(in_b));
      F3_BLTU: w_br_taken = (in_a <  in_b);
      F3_BGEU: w_br_taken = (in_a >= in_b);
      default: w_br_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_taken    = w_br_taken;
    w_illegal  = w_br_illegal;
    w_dest     = in_pc + in_imm;
    w_tgt_only = 1'b0;
`ifdef BRU_JUMP_EN
    if (in_funct3[3]) begin
      w_taken   = 1'b0;
      w_illegal = 1'b1;
      case (bru_op_t'(in_funct3))
        OP_JAL: begin
          w_taken    = 1'b1;
          w_illegal  = 1'b0;
          w_tgt_only = 1'b1;
        end
        OP_JALR: begin
          w_taken    = 1'b1;
          w_illegal  = 1'b0;
          w_tgt_only = 1'b1;
          w_dest     = (in_a + in_imm) & ~XLEN'(1);
        end
        default: ;
      endcase
    end
`endif
    // An illegal op reports "not taken", so it mispredicts exactly when the predictor said taken.
    if (w_illegal)
      w_mispredict = in_pred_taken;
    else if (w_tgt_only)
      w_mispredict = (w_dest != in_pred_tgt);
    else
      w_mispredict = (w_taken != in_pred_taken) ||
                     (w_taken && in_pred_taken && (w_dest != in_pred_tgt));
  end

  always_comb begin
    w_res            = '0;
    w_res.tag        = in_tag;
    w_res.taken      = w_taken;
    w_res.next_pc    = w_taken ? w_dest : w_seq;
    w_res.mispredict = w_mispredict;
    w_res.illegal    = w_illegal;
`ifdef BRU_JUMP_EN
    w_res.link       = w_seq;
`endif
  end

  // Credit check counts S1 so the FIFO push next edge always has room; no path from out_ready.
  assign w_occ    = w_count + CW'(r_s1_valid);
  assign in_ready = (w_occ < CW'(QDEPTH));
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1 <= w_res;
    end
  end

  assign w_pop = out_ready & ~w_empty;

  br_result_fifo #(
    .T     (res_t),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (r_s1_valid),
    .push_data (r_s1),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_full && r_s1_valid && !w_pop));

  assign w_out          = w_empty ? '0 : w_head;
  assign out_valid      = ~w_empty;
  assign out_tag        = w_out.tag;
  assign out_taken      = w_out.taken;
  assign out_next_pc    = w_out.next_pc;
  assign out_mispredict = w_out.mispredict;
  assign out_illegal    = w_out.illegal;
`ifdef BRU_JUMP_EN
  assign out_link       = w_out.link;
`endif

endmodule
